calc_entry_seq: RTL and testbench

CALC_ENTRY_SEQ -- requirements
Module: calc_entry_seq

---
 rtl/calc_entry_seq_pkg.sv | 36 +++
 rtl/bcd_shift2.sv | 43 ++++
 rtl/calc_entry_seq.sv | 172 +++++++++++++++++
 tb/tb_calc_entry_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_entry_seq_pkg.sv
// -----------------------------------------------------------------------------
// calc_entry_seq_pkg
// Shared definitions for the calculator key-entry block.
//   - Global display-phase, BCD width and key-code macros. Other blocks in the
//     system use these too, so they are guarded against redefinition.
//   - Package with the BCD digit type and key classification helpers.
// No ports (package only).
// -----------------------------------------------------------------------------
`ifndef CALC_GLOBAL_DEFS
`define CALC_GLOBAL_DEFS
`define OP_A_IN       2'd0
`define OP_B_IN       2'd1
`define RESULT_OUT    2'd2
`define BCD_BIT_WIDTH 4
`define KEY_ADD       4'hA
`define KEY_SUB       4'hB
`define KEY_ENTER     4'hE
`define KEY_CLR       4'hF
`endif

package calc_entry_seq_pkg;

    localparam int DATA_W = `BCD_BIT_WIDTH;

    typedef logic [DATA_W-1:0] bcd_t;

    // Digit keys are 0..9; codes above 9 are never loaded into an operand.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k == `KEY_ADD) || (k == `KEY_SUB);
    endfunction

endpackage

// File: rtl/bcd_shift2.sv
// -----------------------------------------------------------------------------
// bcd_shift2
// Two-digit BCD shift register used to hold one calculator operand.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset, clears both digits
//   clr      - clear both digits
//   shift_en - shift din into the units digit, units moves to tens
//   din      - incoming digit
//   dout1    - tens digit
//   dout0    - units digit
// With clr and shift_en together the result is {0, din}: a fresh one-digit
// number, used when a new entry starts from the result display.
// -----------------------------------------------------------------------------
module bcd_shift2
    import calc_entry_seq_pkg::*;
#(
    parameter int DATA_W = calc_entry_seq_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout0
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1 <= '0;
            dout0 <= '0;
        end else if (shift_en) begin
            // Oldest tens digit falls off the top: wrap-around entry.
            dout1 <= clr ? '0 : dout0;
            dout0 <= din;
        end else if (clr) begin
            dout1 <= '0;
            dout0 <= '0;
        end
    end

endmodule

// File: rtl/calc_entry_seq.sv
// -----------------------------------------------------------------------------
// calc_entry_seq
// Key-entry sequencer for a two-operand, two-digit BCD calculator.
// Collects operand A, operator, operand B, then requests a computation from
// an external arithmetic unit and holds the operands while the result shows.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   key_valid  - one-cycle key press strobe
//   key_code   - 0-9 digit, A add, B subtract, E enter, F clear (C/D ignored)
//   calc_done  - arithmetic unit completion pulse
//   state      - display phase (OP_A_IN / OP_B_IN / RESULT_OUT)
//   op_a1/0    - operand A tens/units digits
//   op_b1/0    - operand B tens/units digits
//   op_sel     - 0 add, 1 subtract
//   calc_start - one-cycle computation request
//   busy       - high while waiting for calc_done
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module calc_entry_seq
    import calc_entry_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              calc_done,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] op_a1,
    output logic [DATA_W-1:0] op_a0,
    output logic [DATA_W-1:0] op_b1,
    output logic [DATA_W-1:0] op_b0,
    output logic              op_sel,
    output logic              calc_start,
    output logic              busy
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        SHOW    = 2'd3
    } fsm_t;

    fsm_t st_q, st_d;

    logic a_clr, a_shift, b_clr, b_shift;
    logic sel_d, start_d;

    logic key_digit, key_op, key_enter, key_clr;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_op    = key_valid && is_operator(key_code);
    assign key_enter = key_valid && (key_code == `KEY_ENTER);
    assign key_clr   = key_valid && (key_code == `KEY_CLR);

    function automatic logic [1:0] phase_of(input fsm_t s);
        case (s)
            ENTER_A: return `OP_A_IN;
            SHOW:    return `RESULT_OUT;
            default: return `OP_B_IN;   // ENTER_B and CALC
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ENTER_A;
            state      <= `OP_A_IN;
            op_sel     <= 1'b0;
            calc_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            st_q       <= st_d;
            state      <= phase_of(st_d);
            op_sel     <= sel_d;
            calc_start <= start_d;
            busy       <= (st_d == CALC);
        end
    end

    always_comb begin
        st_d    = st_q;
        sel_d   = op_sel;
        start_d = 1'b0;
        a_clr   = 1'b0;
        a_shift = 1'b0;
        b_clr   = 1'b0;
        b_shift = 1'b0;

        case (st_q)
            ENTER_A: begin
                if (key_digit) begin
                    a_shift = 1'b1;
                end else if (key_op) begin
                    sel_d = (key_code == `KEY_SUB);
                    b_clr = 1'b1;
                    st_d  = ENTER_B;
                end else if (key_clr) begin
                    a_clr = 1'b1;
                    b_clr = 1'b1;
                    sel_d = 1'b0;
                end
            end

            ENTER_B: begin
                if (key_digit) begin
                    b_shift = 1'b1;
                end else if (key_op) begin
                    sel_d = (key_code == `KEY_SUB);
                end else if (key_enter) begin
                    start_d = 1'b1;
                    st_d    = CALC;
                end else if (key_clr) begin
                    a_clr = 1'b1;
                    b_clr = 1'b1;
                    sel_d = 1'b0;
                    st_d  = ENTER_A;
                end
            end

            // Keys (including clear) are locked out until the result arrives.
            CALC: begin
                if (calc_done) begin
                    st_d = SHOW;
                end
            end

            SHOW: begin
                if (key_digit) begin
                    // clear + shift loads {0, key} as a new operand A
                    a_clr   = 1'b1;
                    a_shift = 1'b1;
                    b_clr   = 1'b1;
                    st_d    = ENTER_A;
                end else if (key_op) begin
                    // Chaining: operand A is kept, a new operand B follows.
                    sel_d = (key_code == `KEY_SUB);
                    b_clr = 1'b1;
                    st_d  = ENTER_B;
                end else if (key_clr) begin
                    a_clr = 1'b1;
                    b_clr = 1'b1;
                    sel_d = 1'b0;
                    st_d  = ENTER_A;
                end
            end

            default: st_d = ENTER_A;
        endcase
    end

    bcd_shift2 #(.DATA_W(DATA_W)) u_op_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (a_clr),
        .shift_en (a_shift),
        .din      (key_code),
        .dout1    (op_a1),
        .dout0    (op_a0)
    );

    bcd_shift2 #(.DATA_W(DATA_W)) u_op_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (b_clr),
        .shift_en (b_shift),
        .din      (key_code),
        .dout1    (op_b1),
        .dout0    (op_b0)
    );

endmodule

// File: tb/tb_calc_entry_seq.sv
// Directed bench for calc_entry_seq. Stimulus pushes hand-computed expected
// snapshots and expected calc_start operand sets into queues; a monitor
// compares them at the falling edge.
module tb_calc_entry_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       calc_done;
    logic [1:0] state;
    logic [3:0] op_a1, op_a0, op_b1, op_b0;
    logic       op_sel, calc_start, busy;

    int checks   = 0;
    int failures = 0;
    int start_seen = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] a1, a0, b1, b0;
        logic       sel, bsy, start;
    } snap_t;

    typedef struct {
        string      name;
        logic [3:0] a1, a0, b1, b0;
        logic       sel;
    } start_t;

    snap_t  snap_q[$];
    start_t start_q[$];

    calc_entry_seq dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .calc_done  (calc_done),
        .state      (state),
        .op_a1      (op_a1),
        .op_a0      (op_a0),
        .op_b1      (op_b1),
        .op_b0      (op_b0),
        .op_sel     (op_sel),
        .calc_start (calc_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: snapshots and calc_start pulses checked at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                snap_t e;
                e = snap_q.pop_front();
                checks++;
                if ({state, op_a1, op_a0, op_b1, op_b0, op_sel, busy, calc_start} !==
                    {e.st, e.a1, e.a0, e.b1, e.b0, e.sel, e.bsy, e.start}) begin
                    failures++;
                    $display("FAIL %s: got st=%0d a=%h%h b=%h%h sel=%b busy=%b start=%b, want st=%0d a=%h%h b=%h%h sel=%b busy=%b start=%b",
                             e.name, state, op_a1, op_a0, op_b1, op_b0, op_sel, busy, calc_start,
                             e.st, e.a1, e.a0, e.b1, e.b0, e.sel, e.bsy, e.start);
                end
            end
            if (calc_start === 1'b1) begin
                start_seen++;
                checks++;
                if (start_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_calc_start: got pulse with a=%h%h b=%h%h, want none",
                             op_a1, op_a0, op_b1, op_b0);
                end else begin
                    start_t s;
                    s = start_q.pop_front();
                    if ({op_a1, op_a0, op_b1, op_b0, op_sel} !== {s.a1, s.a0, s.b1, s.b0, s.sel}) begin
                        failures++;
                        $display("FAIL %s: got a=%h%h b=%h%h sel=%b at calc_start, want a=%h%h b=%h%h sel=%b",
                                 s.name, op_a1, op_a0, op_b1, op_b0, op_sel, s.a1, s.a0, s.b1, s.b0, s.sel);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expect_snap(input string n, input logic [1:0] st,
                               input logic [3:0] a1, input logic [3:0] a0,
                               input logic [3:0] b1, input logic [3:0] b0,
                               input logic sel, input logic bsy, input logic start);
        snap_t e;
        e.name = n; e.st = st; e.a1 = a1; e.a0 = a0; e.b1 = b1; e.b0 = b0;
        e.sel = sel; e.bsy = bsy; e.start = start;
        snap_q.push_back(e);
    endtask

    task automatic expect_start(input string n, input logic [3:0] a1, input logic [3:0] a0,
                                input logic [3:0] b1, input logic [3:0] b0, input logic sel);
        start_t s;
        s.name = n; s.a1 = a1; s.a0 = a0; s.b1 = b1; s.b0 = b0; s.sel = sel;
        start_q.push_back(s);
    endtask

    // One-cycle key press; returns #1 after the edge that samples it.
    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
    endtask

    // Let the monitor consume pending expectations before the next stimulus.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        calc_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_snap("reset_state", `OP_A_IN, 0, 0, 0, 0, 0, 0, 0);
        settle();
        @(posedge clk); #1;
        rst = 1'b0;

        // Entry of A with wrap-around of the third digit
        press(4'h1); press(4'h2); press(4'h3);
        expect_snap("a_keys_123", `OP_A_IN, 2, 3, 0, 0, 0, 0, 0); settle();
        press(4'hC); press(4'hD);
        expect_snap("ignored_codes_cd", `OP_A_IN, 2, 3, 0, 0, 0, 0, 0); settle();
        @(posedge clk); #1; key_code = 4'h5;
        @(posedge clk); #1;
        expect_snap("key_without_valid", `OP_A_IN, 2, 3, 0, 0, 0, 0, 0); settle();
        press(4'hE);
        expect_snap("enter_in_enter_a", `OP_A_IN, 2, 3, 0, 0, 0, 0, 0); settle();

        // 45 + 67
        press(4'h4); press(4'h5);
        expect_snap("a_keys_45", `OP_A_IN, 4, 5, 0, 0, 0, 0, 0); settle();
        press(4'hA);
        expect_snap("op_add_to_b", `OP_B_IN, 4, 5, 0, 0, 0, 0, 0); settle();
        press(4'h6); press(4'h7);
        expect_snap("b_keys_67", `OP_B_IN, 4, 5, 6, 7, 0, 0, 0); settle();
        expect_start("start_45_plus_67", 4, 5, 6, 7, 0);
        press(4'hE);
        expect_snap("enter_to_calc", `OP_B_IN, 4, 5, 6, 7, 0, 1, 1); settle();
        expect_snap("calc_start_one_cycle", `OP_B_IN, 4, 5, 6, 7, 0, 1, 0); settle();
        press(4'hF);
        expect_snap("clear_in_calc_ignored", `OP_B_IN, 4, 5, 6, 7, 0, 1, 0); settle();
        press(4'h8);
        expect_snap("digit_in_calc_ignored", `OP_B_IN, 4, 5, 6, 7, 0, 1, 0); settle();
        pulse_done();
        expect_snap("done_to_show", `RESULT_OUT, 4, 5, 6, 7, 0, 0, 0); settle();
        press(4'hE);
        expect_snap("enter_in_show", `RESULT_OUT, 4, 5, 6, 7, 0, 0, 0); settle();

        // Chaining: 45 - 01
        press(4'hB);
        expect_snap("chain_sub", `OP_B_IN, 4, 5, 0, 0, 1, 0, 0); settle();
        press(4'h1);
        expect_snap("chain_b_01", `OP_B_IN, 4, 5, 0, 1, 1, 0, 0); settle();
        press(4'hA);
        expect_snap("op_in_b_updates_sel", `OP_B_IN, 4, 5, 0, 1, 0, 0, 0); settle();
        press(4'hB);
        expect_start("start_45_minus_01", 4, 5, 0, 1, 1);
        press(4'hE);
        expect_snap("chain_enter", `OP_B_IN, 4, 5, 0, 1, 1, 1, 1); settle();
        pulse_done();
        expect_snap("chain_show", `RESULT_OUT, 4, 5, 0, 1, 1, 0, 0); settle();

        // Digit from result display starts a fresh A
        press(4'h9);
        expect_snap("show_digit_new_a", `OP_A_IN, 0, 9, 0, 0, 1, 0, 0); settle();
        pulse_done();
        expect_snap("stray_done_enter_a", `OP_A_IN, 0, 9, 0, 0, 1, 0, 0); settle();
        press(4'hA); press(4'h3);
        expect_snap("b_after_new_a", `OP_B_IN, 0, 9, 0, 3, 0, 0, 0); settle();
        press(4'hF);
        expect_snap("clear_in_enter_b", `OP_A_IN, 0, 0, 0, 0, 0, 0, 0); settle();

        // Reset in the middle of a computation
        press(4'h2); press(4'hB); press(4'h5);
        expect_start("start_before_reset", 0, 2, 0, 5, 1);
        press(4'hE);
        expect_snap("calc_before_reset", `OP_B_IN, 0, 2, 0, 5, 1, 1, 1); settle();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        expect_snap("async_reset_mid_calc", `OP_A_IN, 0, 0, 0, 0, 0, 0, 0); settle();
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_done();
        expect_snap("late_done_ignored", `OP_A_IN, 0, 0, 0, 0, 0, 0, 0); settle();
        press(4'h7);
        expect_snap("keys_after_reset", `OP_A_IN, 0, 7, 0, 0, 0, 0, 0); settle();

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (start_seen != 3 || start_q.size() != 0) begin
            failures++;
            $display("FAIL calc_start_count: got %0d pulses (%0d expected pending), want 3 (0 pending)",
                     start_seen, start_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
